// File: rtl/nes_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : nes_cpu_pkg
// Brief  : Shared types and constants for the PC vector sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
package nes_cpu_pkg;

    localparam int MEM_ADDR_SIZE = 16;

    localparam logic [MEM_ADDR_SIZE-1:0] VEC_NMI_ADDR = 16'hFFFA;
    localparam logic [MEM_ADDR_SIZE-1:0] VEC_RST_ADDR = 16'hFFFC;
    localparam logic [MEM_ADDR_SIZE-1:0] VEC_IRQ_ADDR = 16'hFFFE;

    typedef enum logic [1:0] {
        VK_RST = 2'd0,
        VK_NMI = 2'd1,
        VK_IRQ = 2'd2,
        VK_BRK = 2'd3
    } vec_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH_LO = 2'd1,
        ST_FETCH_HI = 2'd2,
        ST_LOAD     = 2'd3
    } pc_seq_state_e;

endpackage
`default_nettype wire

// File: rtl/pc_seq_edge_det.sv
`default_nettype none
// ============================================================================
// Module : pc_seq_edge_det
// Brief  : Rising-edge latch; pending flag sets on 0->1 and clears on request.
// Rev    : 1.0 - initial release
// ============================================================================
module pc_seq_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    input  logic clr_i,
    output logic pend_o
);

    logic sig_q;
    logic pend_q;

    // A fresh edge beats a clear in the same cycle so that event is not lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sig_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
            if (sig_i && !sig_q) begin
                pend_q <= 1'b1;
            end else if (clr_i) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign pend_o = pend_q;

endmodule
`default_nettype wire

// File: rtl/pc_vector_seq.sv
`default_nettype none
// ============================================================================
// Module : pc_vector_seq
// Brief  : Sequences PC loads: registered branch redirects and 2-byte
//          RESET/NMI/IRQ/BRK vector fetches. Define PC_VEC_SEQ_IRQ_EN to
//          enable the IRQ path.
// Rev    : 1.0 - initial release
// ============================================================================
module pc_vector_seq
    import nes_cpu_pkg::*;
#(
    parameter logic [MEM_ADDR_SIZE-1:0] VEC_NMI = VEC_NMI_ADDR,
    parameter logic [MEM_ADDR_SIZE-1:0] VEC_RST = VEC_RST_ADDR,
    parameter logic [MEM_ADDR_SIZE-1:0] VEC_IRQ = VEC_IRQ_ADDR
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     boundary_i,
    input  logic                     nmi_i,
    input  logic                     irq_i,
    input  logic                     irq_mask_i,
    input  logic                     brk_i,
    input  logic                     branch_req_i,
    input  logic [MEM_ADDR_SIZE-1:0] branch_pc_i,
    output logic                     mem_req_o,
    output logic [MEM_ADDR_SIZE-1:0] mem_addr_o,
    input  logic [7:0]               mem_rdata_i,
    input  logic                     mem_valid_i,
    output logic                     pc_load_o,
    output logic [MEM_ADDR_SIZE-1:0] pc_new_o,
    output logic                     busy_o,
    output logic [1:0]               vec_kind_o
);

    pc_seq_state_e            state_q, state_d;
    vec_kind_e                kind_q, kind_d;
    logic [7:0]               lo_q, lo_d;
    logic                     pc_load_q, pc_load_d;
    logic [MEM_ADDR_SIZE-1:0] pc_new_q, pc_new_d;

    logic                     w_nmi_pend;
    logic                     w_nmi_clr;
    logic                     w_irq_take;
    logic                     w_mem_req;
    logic                     w_hi_sel;
    logic [MEM_ADDR_SIZE-1:0] w_vec_base;

`ifdef PC_VEC_SEQ_IRQ_EN
    assign w_irq_take = irq_i & ~irq_mask_i;
`else
    logic w_unused_irq;
    assign w_unused_irq = irq_i | irq_mask_i;
    assign w_irq_take   = 1'b0;
`endif

    pc_seq_edge_det u_nmi_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sig_i  (nmi_i),
        .clr_i  (w_nmi_clr),
        .pend_o (w_nmi_pend)
    );

    always_comb begin
        w_vec_base = VEC_IRQ;
        case (kind_q)
            VK_RST:  w_vec_base = VEC_RST;
            VK_NMI:  w_vec_base = VEC_NMI;
            default: w_vec_base = VEC_IRQ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        lo_d      = lo_q;
        pc_load_d = 1'b0;
        pc_new_d  = pc_new_q;
        w_nmi_clr = 1'b0;
        w_mem_req = 1'b0;
        w_hi_sel  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // An event at a boundary always wins over a same-cycle branch.
                if (boundary_i && (w_nmi_pend || brk_i || w_irq_take)) begin
                    state_d = ST_FETCH_LO;
                    if (w_nmi_pend) begin
                        kind_d    = VK_NMI;
                        w_nmi_clr = 1'b1;
                    end else if (brk_i) begin
                        kind_d = VK_BRK;
                    end else begin
                        kind_d = VK_IRQ;
                    end
                end else if (branch_req_i) begin
                    pc_load_d = 1'b1;
                    pc_new_d  = branch_pc_i;
                end
            end
            ST_FETCH_LO: begin
                w_mem_req = 1'b1;
                if (mem_valid_i) begin
                    lo_d    = mem_rdata_i;
                    state_d = ST_FETCH_HI;
                end
            end
            ST_FETCH_HI: begin
                w_mem_req = 1'b1;
                w_hi_sel  = 1'b1;
                if (mem_valid_i) begin
                    pc_load_d = 1'b1;
                    pc_new_d  = {mem_rdata_i, lo_q};
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_FETCH_LO;
            kind_q    <= VK_RST;
            lo_q      <= 8'h00;
            pc_load_q <= 1'b0;
            pc_new_q  <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            lo_q      <= lo_d;
            pc_load_q <= pc_load_d;
            pc_new_q  <= pc_new_d;
        end
    end

    // The request is held off while reset is asserted so the reset cycle is quiet.
    assign mem_req_o  = w_mem_req & ~rst_i;
    assign mem_addr_o = w_hi_sel ? (w_vec_base + {{(MEM_ADDR_SIZE-1){1'b0}}, 1'b1}) : w_vec_base;
    assign pc_load_o  = pc_load_q;
    assign pc_new_o   = pc_new_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign vec_kind_o = kind_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_vector_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_pc_vector_seq
// Brief  : Scoreboard bench for pc_vector_seq with a transaction-level model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_pc_vector_seq;

`ifdef PC_VEC_SEQ_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] pc;
        logic [1:0]  kind;
        logic        busy;
    } ld_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        boundary_i = 1'b0;
    logic        nmi_i = 1'b0;
    logic        irq_i = 1'b0;
    logic        irq_mask_i = 1'b0;
    logic        brk_i = 1'b0;
    logic        branch_req_i = 1'b0;
    logic [15:0] branch_pc_i = 16'h0000;
    logic        mem_req_o;
    logic [15:0] mem_addr_o;
    logic [7:0]  mem_rdata_i;
    logic        mem_valid_i;
    logic        pc_load_o;
    logic [15:0] pc_new_o;
    logic        busy_o;
    logic [1:0]  vec_kind_o;

    int          total = 0;
    int          bad = 0;
    int          wait_cfg = 0;
    bit          spurious_en = 1'b0;
    logic [7:0]  mem [0:65535];
    logic [15:0] exp_rd [$];
    ld_t         exp_ld [$];
    bit          nmi_pend = 1'b0;
    logic [1:0]  last_kind = 2'd0;

    pc_vector_seq dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .boundary_i   (boundary_i),
        .nmi_i        (nmi_i),
        .irq_i        (irq_i),
        .irq_mask_i   (irq_mask_i),
        .brk_i        (brk_i),
        .branch_req_i (branch_req_i),
        .branch_pc_i  (branch_pc_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_valid_i  (mem_valid_i),
        .pc_load_o    (pc_load_o),
        .pc_new_o     (pc_new_o),
        .busy_o       (busy_o),
        .vec_kind_o   (vec_kind_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    function automatic logic [15:0] vec_of(input logic [1:0] k);
        case (k)
            2'd0:    return 16'hFFFC;
            2'd1:    return 16'hFFFA;
            default: return 16'hFFFE;
        endcase
    endfunction

    // Expected outcome of one vector sequence: two byte reads then one load.
    task automatic push_vec(input logic [1:0] k);
        logic [15:0] v;
        logic [15:0] v1;
        v  = vec_of(k);
        v1 = v + 16'd1;
        exp_rd.push_back(v);
        exp_rd.push_back(v1);
        exp_ld.push_back('{pc: {mem[v1], mem[v]}, kind: k, busy: 1'b1});
        last_kind = k;
    endtask

    // Memory responder with a configurable wait count per byte.
    initial begin
        int wcnt;
        wcnt = 0;
        mem_valid_i = 1'b0;
        mem_rdata_i = 8'h00;
        forever begin
            @(posedge clk_i);
            #2;
            if (mem_req_o && !rst_i) begin
                if (wcnt >= wait_cfg) begin
                    mem_valid_i = 1'b1;
                    mem_rdata_i = mem[mem_addr_o];
                    wcnt = 0;
                end else begin
                    mem_valid_i = 1'b0;
                    wcnt++;
                end
            end else begin
                wcnt = 0;
                mem_valid_i = spurious_en && ($urandom_range(0, 1) == 1);
                mem_rdata_i = 8'($urandom);
            end
        end
    end

    // Monitor: compares every presented read and every PC load.
    initial begin
        ld_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (mem_req_o) begin
                    if (exp_rd.size() == 0) begin
                        chk("rd_unexpected", {16'h0, mem_addr_o}, 32'hFFFF_FFFF);
                    end else begin
                        chk("rd_addr", {16'h0, mem_addr_o}, {16'h0, exp_rd[0]});
                        if (mem_valid_i) void'(exp_rd.pop_front());
                    end
                end
                if (pc_load_o) begin
                    if (exp_ld.size() == 0) begin
                        chk("ld_unexpected", {16'h0, pc_new_o}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_ld.pop_front();
                        chk("ld_pc", {16'h0, pc_new_o}, {16'h0, e.pc});
                        chk("ld_kind", {30'h0, vec_kind_o}, {30'h0, e.kind});
                        chk("ld_busy", {31'h0, busy_o}, {31'h0, e.busy});
                    end
                end
            end
        end
    end

    task automatic wait_load(input bit nmi_mid, input int k0, output int kf);
        kf = 0;
        for (int k = k0; k <= 80; k++) begin
            @(posedge clk_i);
            #1;
            if (nmi_mid && k == 2) nmi_i = 1'b1;
            if (nmi_mid && k == 3) begin
                nmi_i = 1'b0;
                nmi_pend = 1'b1;
            end
            if (pc_load_o) begin
                kf = k;
                break;
            end
        end
        chk("load_seen", {31'h0, kf != 0}, 32'd1);
        if (kf != 0) begin
            @(posedge clk_i);
            #1;
            chk("busy_fall", {31'h0, busy_o}, 32'd0);
            chk("load_once", {31'h0, pc_load_o}, 32'd0);
        end
    endtask

    task automatic do_reset(input int w);
        int kf;
        rst_i = 1'b1;
        wait_cfg = w;
        exp_rd.delete();
        exp_ld.delete();
        nmi_pend = 1'b0;
        @(posedge clk_i);
        #1;
        chk("rst_pc_load", {31'h0, pc_load_o}, 32'd0);
        chk("rst_pc_new", {16'h0, pc_new_o}, 32'd0);
        chk("rst_mem_req", {31'h0, mem_req_o}, 32'd0);
        chk("rst_kind", {30'h0, vec_kind_o}, 32'd0);
        push_vec(2'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("rst_exit_busy", {31'h0, busy_o}, 32'd1);
        wait_load(1'b0, 1, kf);
        if (kf != 0) chk("rst_latency", kf, 2 * (w + 1));
    endtask

    // One idle-state cycle of core inputs, then follow whatever it triggers.
    task automatic do_op(input bit bnd, input bit brk, input bit irq, input bit mask,
                         input bit br, input logic [15:0] bpc, input int w, input bit nmi_mid);
        int         win;
        int         kf;
        win = -1;
        if (bnd) begin
            if (nmi_pend)                   win = 1;
            else if (brk)                   win = 3;
            else if (IRQ_EN && irq && !mask) win = 2;
        end
        wait_cfg = w;
        if (win >= 0) begin
            push_vec(2'(win));
            if (win == 1) nmi_pend = 1'b0;
        end else if (br) begin
            exp_ld.push_back('{pc: bpc, kind: last_kind, busy: 1'b0});
        end
        boundary_i = bnd;
        brk_i = brk;
        irq_i = irq;
        irq_mask_i = mask;
        branch_req_i = br;
        branch_pc_i = bpc;
        @(posedge clk_i);
        #1;
        boundary_i = 1'b0;
        brk_i = 1'b0;
        irq_i = 1'b0;
        branch_req_i = 1'b0;
        if (win >= 0) begin
            chk("seq_busy", {31'h0, busy_o}, 32'd1);
            wait_load(nmi_mid, 2, kf);
            if (kf != 0) chk("seq_latency", kf - 1, 2 * (w + 1));
        end else if (br) begin
            chk("br_latency", {31'h0, pc_load_o}, 32'd1);
            @(posedge clk_i);
            #1;
            chk("br_once", {31'h0, pc_load_o}, 32'd0);
        end else begin
            repeat (2) @(posedge clk_i);
            #1;
            chk("no_seq_busy", {31'h0, busy_o}, 32'd0);
        end
    endtask

    task automatic pulse_nmi();
        nmi_i = 1'b1;
        @(posedge clk_i);
        #1;
        nmi_i = 1'b0;
        nmi_pend = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic rand_vectors();
        for (int a = 16'hFFFA; a <= 16'hFFFF; a++) mem[a] = 8'($urandom);
    endtask

    task automatic reset_mid_fetch();
        bit found;
        rand_vectors();
        wait_cfg = 3;
        push_vec(2'd3);
        boundary_i = 1'b1;
        brk_i = 1'b1;
        @(posedge clk_i);
        #1;
        boundary_i = 1'b0;
        brk_i = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (mem_req_o && mem_addr_o == 16'hFFFF) begin
                found = 1'b1;
                break;
            end
            @(posedge clk_i);
            #1;
        end
        chk("hi_reached", {31'h0, found}, 32'd1);
        mem[16'hFFFC] = 8'h78;
        mem[16'hFFFD] = 8'h56;
        do_reset(1);
    endtask

    initial begin
        rand_vectors();
        mem[16'hFFFC] = 8'h34;
        mem[16'hFFFD] = 8'h12;
        do_reset(0);

        do_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hC0DE, 0, 1'b0);

        mem[16'hFFFA] = 8'h00;
        mem[16'hFFFB] = 8'h90;
        do_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1, 1'b1);
        do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b0);

        do_op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 0, 1'b0);
        do_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
        do_op(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b0);
        do_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'hBEEF, 3, 1'b0);

        reset_mid_fetch();

        spurious_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rand_vectors();
            if ($urandom_range(0, 3) == 0) pulse_nmi();
            do_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end
        spurious_en = 1'b0;

        repeat (3) @(posedge clk_i);
        #1;
        chk("rd_queue_empty", exp_rd.size(), 0);
        chk("ld_queue_empty", exp_ld.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
